// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with frame debounce and valid/ack output.
// Define KEYPAD_ASCII_EN to register a lowercase ASCII copy of each accepted key.
module keypad_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_down,
  output logic       overrun,
  output logic [7:0] key_ascii
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DEB_MAX  = SW'(DEBOUNCE_SCANS);

  typedef enum logic {IDLE, PRESSED} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_meta;
  logic [3:0]    r_sync;
  logic [DW-1:0] r_div;
  logic [1:0]    r_idx;
  logic [3:0]    r_col;
  logic          r_cand_hit;
  logic [3:0]    r_cand_code;
  logic          r_prev_hit;
  logic [3:0]    r_prev_code;
  logic [SW-1:0] r_stable;
  logic [3:0]    r_key;
  logic          r_valid;
  logic          r_ovr;

  logic          w_tc;
  logic          w_frame_end;
  logic          w_row_hit;
  logic [3:0]    w_code;
  logic          w_frame_hit;
  logic [3:0]    w_frame_code;
  logic          w_same;
  logic [SW-1:0] w_stable_nxt;
  logic          w_settled;
  logic          w_accept;
  logic [1:0]    w_idx_nxt;

  function automatic logic [1:0] first_low(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [3:0] keymap(input logic [1:0] c,
                                        input logic [1:0] r);
    logic [3:0] v;
    case ({c, r})
      4'h0:    v = 4'h1;
      4'h1:    v = 4'h4;
      4'h2:    v = 4'h7;
      4'h3:    v = 4'h0;
      4'h4:    v = 4'h2;
      4'h5:    v = 4'h5;
      4'h6:    v = 4'h8;
      4'h7:    v = 4'hF;
      4'h8:    v = 4'h3;
      4'h9:    v = 4'h6;
      4'hA:    v = 4'h9;
      4'hB:    v = 4'hE;
      4'hC:    v = 4'hA;
      4'hD:    v = 4'hB;
      4'hE:    v = 4'hC;
      default: v = 4'hD;
    endcase
    return v;
  endfunction

  assign w_tc        = (r_div == DIV_LAST);
  assign w_frame_end = w_tc && (r_idx == 2'd3);
  assign w_idx_nxt   = r_idx + 2'd1;
  assign w_row_hit   = ~&r_sync;
  assign w_code      = keymap(r_idx, first_low(r_sync));

  // Earlier columns win, so a later hit never overrides the candidate
  assign w_frame_hit  = r_cand_hit || w_row_hit;
  assign w_frame_code = r_cand_hit ? r_cand_code : w_code;

  assign w_same = (w_frame_hit == r_prev_hit) &&
                  (!w_frame_hit || (w_frame_code == r_prev_code));
  assign w_stable_nxt = !w_same              ? SW'(1)  :
                        (r_stable == DEB_MAX) ? DEB_MAX :
                        r_stable + SW'(1);
  assign w_settled = (w_stable_nxt == DEB_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_frame_end && w_settled && w_frame_hit) begin
          w_accept    = 1'b1;
          w_state_nxt = PRESSED;
        end
      end
      PRESSED: begin
        if (w_frame_end && w_settled && !w_frame_hit)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta      <= 4'hF;
      r_sync      <= 4'hF;
      r_div       <= '0;
      r_idx       <= 2'd0;
      r_col       <= 4'b1110;
      r_cand_hit  <= 1'b0;
      r_cand_code <= 4'h0;
      r_prev_hit  <= 1'b0;
      r_prev_code <= 4'h0;
      r_stable    <= '0;
    end else begin
      r_meta <= row;
      r_sync <= r_meta;
      if (w_tc) begin
        r_div <= '0;
        r_idx <= w_idx_nxt;
        r_col <= ~(4'b0001 << w_idx_nxt);
        if (w_frame_end) begin
          r_cand_hit  <= 1'b0;
          r_prev_hit  <= w_frame_hit;
          r_prev_code <= w_frame_code;
          r_stable    <= w_stable_nxt;
        end else if (!r_cand_hit && w_row_hit) begin
          r_cand_hit  <= 1'b1;
          r_cand_code <= w_code;
        end
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  // An accept beats a coincident ack; overrun clears only via ack
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key   <= 4'h0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_accept) begin
      r_key   <= w_frame_code;
      r_valid <= 1'b1;
      r_ovr   <= r_valid && !key_ack;
    end else if (key_ack) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

`ifdef KEYPAD_ASCII_EN
  logic [7:0] r_ascii;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ascii <= 8'h20;
    end else if (w_accept) begin
      if (w_frame_code < 4'hA) r_ascii <= 8'h30 + {4'h0, w_frame_code};
      else                     r_ascii <= 8'h57 + {4'h0, w_frame_code};
    end
  end
  assign key_ascii = r_ascii;
`else
  assign key_ascii = 8'h00;
`endif

  assign col       = r_col;
  assign key       = r_key;
  assign key_valid = r_valid;
  assign key_down  = (r_state == PRESSED);
  assign overrun   = r_ovr;

endmodule
